decide_across_bin: RTL
======================

# decide_across_bin

Global decision engine for the bin manager: on request, scans the global var-states RAM from address 0 upward for the first unassigned variable and writes it back as a new decision at level `cur_lvl_i+1`. It is the forward counterpart of cross-bin backtracking: that step clears and flips assignments, while this block creates them. It owns the var-states RAM port while `apply_dcd_o` is high and reports the chosen variable, or reports that every variable is assigned (SAT).

## Interface
- `WIDTH_VAR`, 12, variable-count/index width
- `WIDTH_LVL`, 16, decision level width
- `WIDTH_VAR_STATES`, 30, var-states RAM word width
- `ADDR_WIDTH_VAR_STATES`, 9, var-states RAM address width
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-low
- `start_dcd_i` in 1: single-cycle request; sampled only in IDLE
- `nv_all_i` in `WIDTH_VAR`: number of variables (addresses 0..nv_all_i-1); held stable while busy
- `cur_lvl_i` in `WIDTH_LVL`: current global level; held stable while busy
- `apply_dcd_o` out 1: level signal, high while not IDLE; used as RAM mux select
- `done_dcd_o` out 1: one-cycle completion pulse
- `all_assigned_o` out 1: valid with `done_dcd_o`; 1 = no unassigned variable found
- `dcd_var_o` out `WIDTH_VAR`: chosen variable address; valid with `done_dcd_o` when `all_assigned_o`=0
- `dcd_lvl_o` out `WIDTH_LVL`: new level (`cur_lvl_i+1`); valid with `done_dcd_o`
- `ram_raddr_vs_o` out `ADDR_WIDTH_VAR_STATES`: read address
- `ram_rdata_vs_i` in `WIDTH_VAR_STATES`: read data, one cycle after the address
- `ram_we_vs_o`, `ram_waddr_vs_o`, `ram_wdata_vs_o` out 1 / `ADDR_WIDTH_VAR_STATES` / `WIDTH_VAR_STATES`: write port

## Operation
- Word layout: `value[2:0]` = bits `[WIDTH_LVL+2:WIDTH_LVL]`, `lvl` = bits `[WIDTH_LVL-1:0]`; bits above are 0 on write.
- Value encoding:
  - `value[2:1]`: 00 unassigned, 01 false, 10 true.
  - `value[0]`: 1 = implied, 0 = decision.
- Written word: value=3'b010 (false polarity, decision flag 0), lvl=`cur_lvl_i+1` modulo 2^WIDTH_LVL.
- States:
  - IDLE -> SCAN on `start_dcd_i`, or -> DONE directly if `nv_all_i`=0.
  - SCAN: issues read addresses 0,1,2,... one per cycle, up to `nv_all_i-1`. Each returned word is checked against its address delayed one cycle.
    - First word with `value[2:1]`=00 -> WRITE, and address issue stops. Read data still in flight is ignored.
    - Last address checked with none unassigned -> DONE with `all_assigned_o`=1.
  - WRITE: one write cycle, then -> DONE.
  - DONE: pulse `done_dcd_o`, then -> IDLE.
- Exactly one RAM write per found decision; no write on all-assigned or `nv_all_i`=0.
- `start_dcd_i` outside IDLE is ignored.
- Reset values (all outputs registered): every output 0, state IDLE, counters 0. Reset asserted mid-scan aborts at the next edge with `ram_we_vs_o`=0; no partial write.
- `dcd_var_o`, `dcd_lvl_o` and `all_assigned_o` hold their values until the next `start_dcd_i` is accepted.

## Timing
- Start sampled at cycle T; state SCAN at T+1; `ram_raddr_vs_o`=0 at T+2; data for address k arrives at T+3+k.
- First unassigned variable at address k:
  - `ram_we_vs_o`=1 for exactly cycle T+4+k, with `ram_waddr_vs_o`=k.
  - `done_dcd_o` at T+5+k.
- All assigned: `done_dcd_o` at T+4+nv_all_i, `all_assigned_o`=1.
- `nv_all_i`=0: `done_dcd_o` at T+2, `all_assigned_o`=1.
- `apply_dcd_o` rises at T+1 and falls the cycle after `done_dcd_o`.
- Maximum one request per scan; the next start is accepted no earlier than the cycle after `done_dcd_o`.

## Configuration
- `DEBUG_DECIDE_ACROSS_BIN_EN`: when defined, the block `$display`s each state transition and the chosen variable with its level, plus "all assigned". Output format: `%1tns` time, in the bin-manager debug style.
- Without the macro: no simulation output; the logic is identical either way.

## Structure
- Shared bin-manager package holds:
  - value encodings (UNASSIGNED=2'b00, FALSE=2'b01, TRUE=2'b10);
  - the field-offset constants for `value`/`lvl` within the var-states word;
  - the state encodings IDLE/SCAN/WRITE/DONE.
- Single module; no sub-module. The field pack/unpack is a function in the package.

## Test plan
- `nv_all_i`=8; vars 0-2 assigned at lvl 1, var 3 unassigned; `cur_lvl_i`=1, start -> single write to address 3 of value 010 and lvl 2; `dcd_var_o`=3, `dcd_lvl_o`=2, `all_assigned_o`=0; done at T+8.
- `nv_all_i`=5, all assigned -> no write; done at T+9, `all_assigned_o`=1.
- `nv_all_i`=0 -> done at T+2, `all_assigned_o`=1, `ram_we_vs_o` never high.
- Var 0 unassigned, `cur_lvl_i`=16'hFFFF -> write at T+4 to address 0 with lvl 0 (wrap); only one write despite reads in flight.
- Second `start_dcd_i` pulse mid-scan -> ignored, single done; `rst`=0 at T+3 of a scan -> all outputs 0 next edge, no write, IDLE.
- Back-to-back: start again the cycle after done with var 3 now assigned and var 6 unassigned -> writes address 6.

Source files
------------

// File: rtl/decide_across_bin_pkg.sv
// rtl/decide_across_bin_pkg.sv - bin-manager shared encodings, var-states word layout and pack helpers
package decide_across_bin_pkg;

  localparam int BM_WIDTH_VAR             = 12;
  localparam int BM_WIDTH_LVL             = 16;
  localparam int BM_WIDTH_VAR_STATES      = 30;
  localparam int BM_ADDR_WIDTH_VAR_STATES = 9;

  // value[2:0] sits directly above the level field; bits above value are zero on write
  localparam int VS_LVL_LSB = 0;
  localparam int VS_VAL_LSB = BM_WIDTH_LVL;

  typedef enum logic [1:0] {
    VAL_UNASSIGNED = 2'b00,
    VAL_FALSE      = 2'b01,
    VAL_TRUE       = 2'b10
  } val_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [BM_WIDTH_VAR_STATES-1:0] vs_pack(
    input val_e                    pol,
    input logic                    implied,
    input logic [BM_WIDTH_LVL-1:0] lvl
  );
    logic [BM_WIDTH_VAR_STATES-1:0] word;
    word                            = '0;
    word[VS_VAL_LSB +: 3]           = {pol, implied};
    word[VS_LVL_LSB +: BM_WIDTH_LVL] = lvl;
    return word;
  endfunction

  function automatic val_e vs_polarity(input logic [BM_WIDTH_VAR_STATES-1:0] word);
    return val_e'(word[VS_VAL_LSB+1 +: 2]);
  endfunction

endpackage

// File: rtl/decide_across_bin.sv
// rtl/decide_across_bin.sv - scans var-states RAM for the first unassigned variable and writes a new decision
// Optional trace output: define DEBUG_DECIDE_ACROSS_BIN_EN
module decide_across_bin
  import decide_across_bin_pkg::*;
#(
  parameter int WIDTH_VAR             = BM_WIDTH_VAR,
  parameter int WIDTH_LVL             = BM_WIDTH_LVL,
  parameter int WIDTH_VAR_STATES      = BM_WIDTH_VAR_STATES,
  parameter int ADDR_WIDTH_VAR_STATES = BM_ADDR_WIDTH_VAR_STATES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_dcd_i,
  input  logic [WIDTH_VAR-1:0]             nv_all_i,
  input  logic [WIDTH_LVL-1:0]             cur_lvl_i,
  output logic                             apply_dcd_o,
  output logic                             done_dcd_o,
  output logic                             all_assigned_o,
  output logic [WIDTH_VAR-1:0]             dcd_var_o,
  output logic [WIDTH_LVL-1:0]             dcd_lvl_o,
  output logic [ADDR_WIDTH_VAR_STATES-1:0] ram_raddr_vs_o,
  input  logic [WIDTH_VAR_STATES-1:0]      ram_rdata_vs_i,
  output logic                             ram_we_vs_o,
  output logic [ADDR_WIDTH_VAR_STATES-1:0] ram_waddr_vs_o,
  output logic [WIDTH_VAR_STATES-1:0]      ram_wdata_vs_o
);

  state_e                           r_state, w_next;
  logic [WIDTH_VAR-1:0]             r_issue_cnt, r_rd_addr, r_chk_addr, r_dcd_var;
  logic [WIDTH_LVL-1:0]             r_dcd_lvl;
  logic                             r_rd_pend, r_chk_v, r_fin;
  logic                             r_apply, r_done, r_all, r_we;
  logic [ADDR_WIDTH_VAR_STATES-1:0] r_raddr, r_waddr;
  logic [WIDTH_VAR_STATES-1:0]      r_wdata;
  logic                             w_issue, w_hit, w_last;

  // r_chk_v/r_chk_addr track the address whose data is on ram_rdata_vs_i this cycle
  assign w_issue = (r_state == ST_SCAN) && (r_issue_cnt < nv_all_i);
  assign w_hit   = (r_state == ST_SCAN) && !r_fin && r_chk_v &&
                   (vs_polarity(ram_rdata_vs_i) == VAL_UNASSIGNED);
  assign w_last  = (r_state == ST_SCAN) && r_chk_v && (r_chk_addr == nv_all_i - WIDTH_VAR'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start_dcd_i) w_next = ST_SCAN;
      ST_SCAN: begin
        if (r_fin)      w_next = ST_DONE;
        else if (w_hit) w_next = ST_WRITE;
      end
      ST_WRITE: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_issue_cnt <= '0;
      r_rd_addr   <= '0;
      r_chk_addr  <= '0;
      r_rd_pend   <= 1'b0;
      r_chk_v     <= 1'b0;
      r_fin       <= 1'b0;
      r_apply     <= 1'b0;
      r_done      <= 1'b0;
      r_all       <= 1'b0;
      r_we        <= 1'b0;
      r_dcd_var   <= '0;
      r_dcd_lvl   <= '0;
      r_raddr     <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
    end else begin
      r_state    <= w_next;
      r_apply    <= (w_next != ST_IDLE);
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_rd_pend  <= w_issue;
      r_chk_v    <= r_rd_pend;
      r_chk_addr <= r_rd_addr;
      if (w_issue) begin
        r_raddr     <= r_issue_cnt[ADDR_WIDTH_VAR_STATES-1:0];
        r_rd_addr   <= r_issue_cnt;
        r_issue_cnt <= r_issue_cnt + WIDTH_VAR'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (start_dcd_i) begin
            r_issue_cnt <= '0;
            // an empty range finishes after one SCAN cycle, same as the end of a full scan
            r_fin       <= (nv_all_i == '0);
            r_all       <= 1'b0;
            r_dcd_var   <= '0;
            r_dcd_lvl   <= cur_lvl_i + WIDTH_LVL'(1);
          end
        end
        ST_SCAN: begin
          if (r_fin) begin
            r_done <= 1'b1;
            r_all  <= 1'b1;
          end else if (w_hit) begin
            r_we      <= 1'b1;
            r_waddr   <= r_chk_addr[ADDR_WIDTH_VAR_STATES-1:0];
            r_wdata   <= vs_pack(VAL_FALSE, 1'b0, r_dcd_lvl);
            r_dcd_var <= r_chk_addr;
          end else if (w_last) begin
            r_fin <= 1'b1;
          end
        end
        ST_WRITE: r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign apply_dcd_o    = r_apply;
  assign done_dcd_o     = r_done;
  assign all_assigned_o = r_all;
  assign dcd_var_o      = r_dcd_var;
  assign dcd_lvl_o      = r_dcd_lvl;
  assign ram_raddr_vs_o = r_raddr;
  assign ram_we_vs_o    = r_we;
  assign ram_waddr_vs_o = r_waddr;
  assign ram_wdata_vs_o = r_wdata;

`ifdef DEBUG_DECIDE_ACROSS_BIN_EN
  always_ff @(posedge clk) begin
    if (rst && (w_next != r_state))
      $display("%1tns [decide_across_bin] state %s -> %s", $time, r_state.name(), w_next.name());
    if (rst && w_hit)
      $display("%1tns [decide_across_bin] decide var %0d lvl %0d", $time, r_chk_addr, r_dcd_lvl);
    if (rst && r_fin && (r_state == ST_SCAN))
      $display("%1tns [decide_across_bin] all assigned", $time);
  end
`else
`endif

endmodule
